// File: rtl/serial_borrow_select_subtractor.sv
// ============================================================================
// serial_borrow_select_subtractor
//
// Purpose:
//   Multi-cycle subtractor computing iA - iB - iBorrow, SLICE_WIDTH bits per
//   clock, least significant slice first. Each slice forms A_k + ~B_k for both
//   possible carry-ins in parallel, and the registered carry from the previous
//   slice picks one of them. Subtraction is done as A + ~B + ~borrowIn, so the
//   internal carry is the inverse of the running borrow.
//
// Ports:
//   iClk       clock, all state updates on the rising edge
//   iRst       synchronous active-high reset
//   iValid     operands valid           oReady    block can accept operands
//   iA         minuend                  iB        subtrahend
//   iBorrow    borrow-in at the LSB
//   oValid     result valid             iReady    consumer accepts result
//   oDiff      difference               oBorrow   unsigned borrow-out
//   oOverflow  signed overflow of the wrapped result
//
// Configuration:
//   SUB_SATURATE_EN  when defined, oDiff floors to zero whenever the final
//                    borrow is 1; oBorrow/oOverflow are reported unchanged.
// ============================================================================
module serial_borrow_select_subtractor #(
  parameter int DATA_WIDTH  = 8,
  parameter int SLICE_WIDTH = 2
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic [DATA_WIDTH-1:0] iA,
  input  logic [DATA_WIDTH-1:0] iB,
  input  logic                  iBorrow,
  output logic                  oValid,
  input  logic                  iReady,
  output logic [DATA_WIDTH-1:0] oDiff,
  output logic                  oBorrow,
  output logic                  oOverflow
);

  localparam int NUM_SLICES = DATA_WIDTH / SLICE_WIDTH;
  localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NUM_SLICES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } stateT;

  stateT state;
  stateT stateNext;

  logic [DATA_WIDTH-1:0]  aReg;
  logic [DATA_WIDTH-1:0]  bReg;
  logic [DATA_WIDTH-1:0]  resReg;
  logic [DATA_WIDTH-1:0]  resNext;
  logic [DATA_WIDTH-1:0]  diffFinal;
  logic [CNT_W-1:0]       sliceCnt;
  logic                   carry;
  logic [SLICE_WIDTH-1:0] aSlice;
  logic [SLICE_WIDTH-1:0] bSlice;
  logic [SLICE_WIDTH:0]   sumNoCarry;
  logic [SLICE_WIDTH:0]   sumWithCarry;
  logic [SLICE_WIDTH:0]   sumSel;
  logic                   acceptOp;
  logic                   lastSlice;

  assign acceptOp  = iValid && oReady;
  assign lastSlice = (sliceCnt == LAST_SLICE);

  // Slice arithmetic: both carry-in cases are formed up front so the
  // registered carry only has to drive a mux, not a ripple chain.
  always_comb begin
    aSlice       = aReg[sliceCnt*SLICE_WIDTH +: SLICE_WIDTH];
    bSlice       = bReg[sliceCnt*SLICE_WIDTH +: SLICE_WIDTH];
    sumNoCarry   = {1'b0, aSlice} + {1'b0, ~bSlice};
    sumWithCarry = {1'b0, aSlice} + {1'b0, ~bSlice} + (SLICE_WIDTH + 1)'(1);
    sumSel       = carry ? sumWithCarry : sumNoCarry;
    resNext      = resReg;
    resNext[sliceCnt*SLICE_WIDTH +: SLICE_WIDTH] = sumSel[SLICE_WIDTH-1:0];
  end

  // A final carry of 0 means the subtraction borrowed; the saturating build
  // floors the reported difference to zero in that case.
  always_comb begin
    diffFinal = resNext;
`ifdef SUB_SATURATE_EN
    if (!sumSel[SLICE_WIDTH]) begin
      diffFinal = '0;
    end
`endif
  end

  // State register for the IDLE -> RUN -> DONE handshake sequence.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and handshake outputs; RUN always takes exactly NUM_SLICES
  // cycles, there is no early exit.
  always_comb begin
    stateNext = state;
    oReady    = 1'b0;
    oValid    = 1'b0;
    case (state)
      IDLE: begin
        oReady = 1'b1;
        if (iValid) begin
          stateNext = RUN;
        end
      end
      RUN: begin
        if (lastSlice) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        oValid = 1'b1;
        if (iReady) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: operands captured on accept, one slice retired per RUN cycle,
  // and the result registers loaded on the last slice so they stay frozen
  // through DONE and the following IDLE.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      aReg      <= '0;
      bReg      <= '0;
      resReg    <= '0;
      sliceCnt  <= '0;
      carry     <= 1'b0;
      oDiff     <= '0;
      oBorrow   <= 1'b0;
      oOverflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acceptOp) begin
            aReg     <= iA;
            bReg     <= iB;
            resReg   <= '0;
            sliceCnt <= '0;
            carry    <= ~iBorrow;
          end
        end
        RUN: begin
          resReg   <= resNext;
          carry    <= sumSel[SLICE_WIDTH];
          sliceCnt <= sliceCnt + CNT_W'(1);
          if (lastSlice) begin
            oDiff     <= diffFinal;
            oBorrow   <= ~sumSel[SLICE_WIDTH];
            oOverflow <= (aReg[DATA_WIDTH-1] != bReg[DATA_WIDTH-1]) &&
                         (resNext[DATA_WIDTH-1] != aReg[DATA_WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_borrow_select_subtractor.sv
// ============================================================================
// tb_serial_borrow_select_subtractor
//
// Purpose:
//   Directed, self-checking bench for serial_borrow_select_subtractor with the
//   default 8-bit / 2-bit-slice configuration. Expected values are computed by
//   hand; the saturating build (SUB_SATURATE_EN) changes only the expected
//   difference of borrowing operations.
// ============================================================================
module tb_serial_borrow_select_subtractor;

`ifdef SUB_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       iClk = 1'b0;
  logic       iRst;
  logic       iValid;
  logic       oReady;
  logic [7:0] iA;
  logic [7:0] iB;
  logic       iBorrow;
  logic       oValid;
  logic       iReady;
  logic [7:0] oDiff;
  logic       oBorrow;
  logic       oOverflow;

  int assertCount = 0;
  int failCount   = 0;
  int latency;

  always #5 iClk = ~iClk;

  serial_borrow_select_subtractor #(
    .DATA_WIDTH (8),
    .SLICE_WIDTH(2)
  ) dut (
    .iClk     (iClk),
    .iRst     (iRst),
    .iValid   (iValid),
    .oReady   (oReady),
    .iA       (iA),
    .iB       (iB),
    .iBorrow  (iBorrow),
    .oValid   (oValid),
    .iReady   (iReady),
    .oDiff    (oDiff),
    .oBorrow  (oBorrow),
    .oOverflow(oOverflow)
  );

  // Advance one clock and settle just past the edge for sampling/driving.
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Present operands for exactly one accepting edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic bor);
    iA      = a;
    iB      = b;
    iBorrow = bor;
    iValid  = 1'b1;
    tick();
    iValid  = 1'b0;
  endtask

  // Count cycles after the accepting edge until oValid, bounded.
  task automatic waitValid(output int cycles);
    cycles = 0;
    while (!oValid && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  task automatic consume();
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
  endtask

  initial begin
    iRst    = 1'b1;
    iValid  = 1'b0;
    iA      = 8'h00;
    iB      = 8'h00;
    iBorrow = 1'b0;
    iReady  = 1'b0;
    tick();
    tick();
    iRst = 1'b0;

    // Reset state
    checkOutput("rst_oReady", oReady, 1);
    checkOutput("rst_oValid", oValid, 0);
    checkOutput("rst_oDiff", oDiff, 8'h00);
    checkOutput("rst_oBorrow", oBorrow, 0);
    checkOutput("rst_oOverflow", oOverflow, 0);

    // 0x5A - 0x23 = 0x37, with latency check
    applyStimulus(8'h5A, 8'h23, 1'b0);
    checkOutput("t1_run_oReady", oReady, 0);
    waitValid(latency);
    checkOutput("t1_latency", latency, 4);
    checkOutput("t1_oDiff", oDiff, 8'h37);
    checkOutput("t1_oBorrow", oBorrow, 0);
    checkOutput("t1_oOverflow", oOverflow, 0);
    consume();
    checkOutput("t1_post_oReady", oReady, 1);
    checkOutput("t1_post_oValid", oValid, 0);
    checkOutput("t1_hold_oDiff", oDiff, 8'h37);

    // 0x10 - 0x20 borrows
    applyStimulus(8'h10, 8'h20, 1'b0);
    waitValid(latency);
    checkOutput("t2_latency", latency, 4);
    checkOutput("t2_oDiff", oDiff, SAT ? 8'h00 : 8'hF0);
    checkOutput("t2_oBorrow", oBorrow, 1);
    checkOutput("t2_oOverflow", oOverflow, 0);
    consume();

    // 0x80 - 0x01 overflows without borrow
    applyStimulus(8'h80, 8'h01, 1'b0);
    waitValid(latency);
    checkOutput("t3a_oDiff", oDiff, 8'h7F);
    checkOutput("t3a_oBorrow", oBorrow, 0);
    checkOutput("t3a_oOverflow", oOverflow, 1);
    consume();

    // 0x7F - 0xFF overflows and borrows
    applyStimulus(8'h7F, 8'hFF, 1'b0);
    waitValid(latency);
    checkOutput("t3b_oDiff", oDiff, SAT ? 8'h00 : 8'h80);
    checkOutput("t3b_oBorrow", oBorrow, 1);
    checkOutput("t3b_oOverflow", oOverflow, 1);
    consume();

    // 0x00 - 0x00 - 1: borrow ripples through every slice
    applyStimulus(8'h00, 8'h00, 1'b1);
    waitValid(latency);
    checkOutput("t4_latency", latency, 4);
    checkOutput("t4_oDiff", oDiff, SAT ? 8'h00 : 8'hFF);
    checkOutput("t4_oBorrow", oBorrow, 1);
    checkOutput("t4_oOverflow", oOverflow, 0);
    consume();

    // Backpressure and ignored operands during RUN: 0xC3 - 0x3C = 0x87
    applyStimulus(8'hC3, 8'h3C, 1'b0);
    iA     = 8'h11;
    iB     = 8'h22;
    iValid = 1'b1;
    tick();
    checkOutput("t5_run_oReady", oReady, 0);
    iValid = 1'b0;
    tick();
    iValid = 1'b1;
    tick();
    checkOutput("t5_run_oValid", oValid, 0);
    iValid = 1'b0;
    waitValid(latency);
    checkOutput("t5_oValid", oValid, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t5_hold_oValid", oValid, 1);
      checkOutput("t5_hold_oReady", oReady, 0);
      checkOutput("t5_hold_oDiff", oDiff, 8'h87);
      checkOutput("t5_hold_oBorrow", oBorrow, 0);
      checkOutput("t5_hold_oOverflow", oOverflow, 0);
    end
    consume();
    checkOutput("t5_post_oReady", oReady, 1);
    checkOutput("t5_post_oValid", oValid, 0);

    // Reset during slice 2 aborts the operation
    applyStimulus(8'h5A, 8'h23, 1'b0);
    tick();
    tick();
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    checkOutput("t6_rst_oReady", oReady, 1);
    checkOutput("t6_rst_oValid", oValid, 0);
    checkOutput("t6_rst_oDiff", oDiff, 8'h00);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("t6_abort_oValid", oValid, 0);
    end
    applyStimulus(8'h03, 8'h05, 1'b0);
    waitValid(latency);
    checkOutput("t6_latency", latency, 4);
    checkOutput("t6_oDiff", oDiff, SAT ? 8'h00 : 8'hFE);
    checkOutput("t6_oBorrow", oBorrow, 1);
    checkOutput("t6_oOverflow", oOverflow, 0);
    consume();
    checkOutput("t6_post_oReady", oReady, 1);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
